// File: rtl/score_display_pkg.sv
// Shared types and seven-segment constants for the score display.
`timescale 1ns/1ps
package score_display_pkg;

  localparam int unsigned NUM_AN = 8;

  typedef logic [3:0] bcd_digit_t;

  // Cathode patterns packed as {a,b,c,d,e,f,g}, active-low.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment cathode decode.
`timescale 1ns/1ps
module bcd_to_seg7
  import score_display_pkg::*;
(
  input  bcd_digit_t digit_i,
  output logic [6:0] seg_o
);

  // Non-BCD codes decode to a dark digit.
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Score keeper and 8-digit multiplexed seven-segment driver.
// Define SCORE_DISPLAY_HISCORE_EN to keep a high score on slots 4 and up.
`timescale 1ns/1ps
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned NDIGITS     = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   points_clk,
  input  logic                   stop,
  input  logic                   clear,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   d,
  output logic                   e,
  output logic                   f,
  output logic                   g,
  output logic [NUM_AN-1:0]      an,
  output logic [4*NDIGITS-1:0]   score_bcd
);

  localparam int unsigned SW   = 4 * NDIGITS;
  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick;
  logic [SW-1:0]          score_q, score_d, score_inc;
  logic                   all_nines;
  logic [CntW-1:0]        refresh_q;
  logic [2:0]             digit_sel_q;
  logic [NUM_AN-1:0]      an_q, an_d;
  logic [6:0]             seg_q, seg_d, seg_dec;
  logic [NDIGITS-1:0]     score_lit;
  bcd_digit_t             digit_mux;
  logic                   slot_lit;

  // Synchronise the points clock and remember the last synchronised level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], points_clk};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

  // BCD ripple increment and all-nines saturation detect.
  always_comb begin
    bcd_digit_t dig;
    logic       carry;
    dig       = '0;
    carry     = 1'b1;
    score_inc = '0;
    all_nines = 1'b1;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      dig = score_q[4*i +: 4];
      if (dig != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (dig == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = dig + 4'd1;
          carry               = 1'b0;
        end
      end else begin
        score_inc[4*i +: 4] = dig;
      end
    end
  end

  // Score next state: clear beats a counted tick, which beats hold.
  always_comb begin
    score_d = score_q;
    if (clear) begin
      score_d = '0;
    end else if (tick && !stop && !all_nines) begin
      score_d = score_inc;
    end
  end

  // Score register.
  always_ff @(posedge clk) begin
    if (!reset_n) score_q <= '0;
    else          score_q <= score_d;
  end

  assign score_bcd = score_q;

  // Leading-zero blanking: a digit is lit if it or any higher digit is non-zero.
  always_comb begin
    logic any_nz;
    any_nz    = 1'b0;
    score_lit = '0;
    for (int i = int'(NDIGITS) - 1; i >= 0; i--) begin
      any_nz       = any_nz | (score_q[4*i +: 4] != 4'd0);
      score_lit[i] = any_nz | (i == 0);
    end
  end

`ifdef SCORE_DISPLAY_HISCORE_EN
  logic [SW-1:0]      hiscore_q;
  logic [NDIGITS-1:0] hiscore_lit;

  // High score tracks the running score one cycle behind; clear leaves it alone.
  always_ff @(posedge clk) begin
    if (!reset_n)                  hiscore_q <= '0;
    else if (score_q > hiscore_q)  hiscore_q <= score_q;
  end

  // Same blanking rule for the high-score half of the display.
  always_comb begin
    logic any_nz;
    any_nz      = 1'b0;
    hiscore_lit = '0;
    for (int i = int'(NDIGITS) - 1; i >= 0; i--) begin
      any_nz         = any_nz | (hiscore_q[4*i +: 4] != 4'd0);
      hiscore_lit[i] = any_nz | (i == 0);
    end
  end
`endif

  // Pick the digit and visibility for the slot currently being scanned.
  always_comb begin
    digit_mux = '0;
    slot_lit  = 1'b0;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (digit_sel_q == 3'(i)) begin
        digit_mux = score_q[4*i +: 4];
        slot_lit  = score_lit[i];
      end
`ifdef SCORE_DISPLAY_HISCORE_EN
      if (digit_sel_q == 3'(i + 4)) begin
        digit_mux = hiscore_q[4*i +: 4];
        slot_lit  = hiscore_lit[i];
      end
`endif
    end
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .digit_i (digit_mux),
    .seg_o   (seg_dec)
  );

  // Drive one anode low for a lit slot, everything dark otherwise.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (slot_lit) begin
      an_d  = ~(NUM_AN'(1) << digit_sel_q);
      seg_d = seg_dec;
    end
  end

  // Refresh divider, slot pointer and registered pin drivers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      refresh_q   <= '0;
      digit_sel_q <= '0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      if (refresh_q == CntW'(REFRESH_DIV - 1)) begin
        refresh_q   <= '0;
        digit_sel_q <= digit_sel_q + 3'd1;
      end else begin
        refresh_q <= refresh_q + CntW'(1);
      end
    end
  end

  assign an                  = an_q;
  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display (REFRESH_DIV shortened to 4).
`timescale 1ns/1ps
module tb_score_display;

  localparam int unsigned NDIGITS     = 4;
  localparam int unsigned REFRESH_DIV = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        reset_n, points_clk, stop, clear;
  logic        a, b, c, d, e, f, g;
  logic [7:0]  an;
  logic [15:0] score_bcd;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  logic       seen [8];
  logic [6:0] sv   [8];
  int         bad;

  assign seg = {a, b, c, d, e, f, g};

  always #5 clk = ~clk;

  score_display #(
    .NDIGITS     (NDIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .points_clk (points_clk),
    .stop       (stop),
    .clear      (clear),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .an         (an),
    .score_bcd  (score_bcd)
  );

  // {a,b,c,d,e,f,g}, active-low; negative digit means a dark slot.
  function automatic logic [6:0] pat(input int dgt);
    case (dgt)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) points_clk = 1'b1;
      @(negedge clk);
      @(negedge clk) points_clk = 1'b0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  // Watch a bit more than one full 8-slot scan and record what each slot showed.
  task automatic scan();
    logic found;
    for (int k = 0; k < 8; k++) begin
      seen[k] = 1'b0;
      sv[k]   = 7'h7F;
    end
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (an == 8'hFF) begin
        if (seg != 7'h7F) bad++;
      end else begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (an == ~(8'b1 << k)) begin
            seen[k] = 1'b1;
            sv[k]   = seg;
            found   = 1'b1;
          end
        end
        if (!found) bad++;
      end
    end
    chk("scan_glitch", bad, 0);
  endtask

  task automatic slot(input string tag, input int k, input int dgt);
    logic [7:0] exp;
    exp = (dgt < 0) ? {1'b0, 7'h7F} : {1'b1, pat(dgt)};
    chk(tag, {seen[k], sv[k]}, exp);
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; points_clk = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an", an, 8'hFF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_score", score_bcd, 16'h0000);

    // First registered slot after release shows a zero on the rightmost digit.
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_an", an, 8'hFE);
    chk("rel_seg", seg, 7'b0000001);
    chk("rel_score", score_bcd, 16'h0000);

    // Tick latency: score moves on the third edge after the rising input.
    @(negedge clk) points_clk = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("lat_early", score_bcd, 16'h0000);
    @(posedge clk); #1;
    chk("lat_hit", score_bcd, 16'h0001);
    @(posedge clk); #1;
    chk("lat_once", score_bcd, 16'h0001);
    @(negedge clk) points_clk = 1'b0;
    ticks(11);
    chk("score_12", score_bcd, 16'h0012);
    scan();
    slot("s12_0", 0, 2);
    slot("s12_1", 1, 1);
    slot("s12_2", 2, -1);
    slot("s12_3", 3, -1);
`ifndef SCORE_DISPLAY_HISCORE_EN
    for (int k = 4; k < 8; k++) slot("s12_hi", k, -1);
`endif

    // Stop freezes the score.
    stop = 1'b1;
    ticks(5);
    chk("stop_hold", score_bcd, 16'h0012);
    stop = 1'b0;

    // Clear coinciding with a tick wins.
    @(negedge clk) points_clk = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk) clear = 1'b1;
    @(posedge clk); #1;
    chk("clear_tick", score_bcd, 16'h0000);
    @(negedge clk) begin clear = 1'b0; points_clk = 1'b0; end
    repeat (3) @(negedge clk);
    chk("clear_hold", score_bcd, 16'h0000);

    // Clear during stop still clears.
    ticks(3);
    chk("score_3", score_bcd, 16'h0003);
    stop = 1'b1;
    pulse_clear();
    chk("clear_stop", score_bcd, 16'h0000);
    stop = 1'b0;

    // Carry chain and blanking around 9 -> 10 and up to 99.
    ticks(9);
    chk("score_9", score_bcd, 16'h0009);
    scan();
    slot("s9_0", 0, 9);
    slot("s9_1", 1, -1);
    ticks(1);
    chk("score_10", score_bcd, 16'h0010);
    scan();
    slot("s10_0", 0, 0);
    slot("s10_1", 1, 1);
    slot("s10_2", 2, -1);
    ticks(89);
    chk("score_99", score_bcd, 16'h0099);
    scan();
    slot("s99_0", 0, 9);
    slot("s99_1", 1, 9);
    slot("s99_2", 2, -1);
    slot("s99_3", 3, -1);

    // Saturation at 9999.
    pulse_clear();
    ticks(9998);
    chk("score_9998", score_bcd, 16'h9998);
    ticks(3);
    chk("score_sat", score_bcd, 16'h9999);
    scan();
    for (int k = 0; k < 4; k++) slot("s9999", k, 9);

    // Mid-scan reset goes dark at once and restarts on slot 0.
    repeat (13) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_an", an, 8'hFF);
    chk("mid_seg", seg, 7'h7F);
    chk("mid_score", score_bcd, 16'h0000);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_an", an, 8'hFE);
    chk("mid_rel_seg", seg, 7'b0000001);

`ifdef SCORE_DISPLAY_HISCORE_EN
    ticks(37);
    pulse_clear();
    ticks(5);
    chk("score_5", score_bcd, 16'h0005);
    scan();
    slot("hi_0", 0, 5);
    slot("hi_1", 1, -1);
    slot("hi_4", 4, 7);
    slot("hi_5", 5, 3);
    slot("hi_6", 6, -1);
    slot("hi_7", 7, -1);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    scan();
    slot("hirst_4", 4, 0);
    slot("hirst_5", 5, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
